// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, streams sequential requests to a
// one-cycle synchronous imem, and buffers {pc, inst, err} for decode.
module fetch_queue #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = {XLEN{1'b0}}
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       imem_en,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       imem_error,
    input  logic                       redir_valid,
    input  logic [XLEN-1:0]            redir_addr,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_inst,
    output logic                       id_err,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam int CW = OW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;
    logic            halted_q, halted_d;
    logic            run_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic            err_mem_q  [DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic            credit;
    logic [CW-1:0]   level;
    logic [XLEN-1:0] redir_aligned;

    assign id_valid      = (count_q != '0);
    assign pop           = id_valid & id_ready;
    assign level         = CW'(count_q) + CW'(inflight_q) - CW'(pop);
    assign credit        = (level < CW'(DEPTH));
    assign redir_aligned = redir_addr & ~XLEN'(3);

    // run_q holds off fetching until the first edge after reset is released.
    assign issue     = run_q & (redir_valid | (credit & ~halted_q));
    assign imem_en   = issue;
    assign imem_addr = redir_valid ? redir_aligned : pc_q;

    // A redirect in the response cycle discards that response.
    assign push = inflight_q & ~kill_q & ~redir_valid;

    assign id_pc     = pc_mem_q[rd_ptr_q];
    assign id_inst   = inst_mem_q[rd_ptr_q];
    assign id_err    = err_mem_q[rd_ptr_q];
    assign occupancy = count_q;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        // A request issued alongside a faulting push must not land after it.
        kill_d     = push & imem_error & issue;
        halted_d   = halted_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (issue) begin
            pc_d     = imem_addr + XLEN'(4);
            req_pc_d = imem_addr;
        end

        if (redir_valid) begin
            halted_d = 1'b0;
        end else if (push && imem_error) begin
            halted_d = 1'b1;
        end

        if (redir_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q       <= RESET_ADDR;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            halted_q   <= 1'b0;
            run_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            halted_q   <= halted_d;
            run_q      <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage is cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                err_mem_q[i]  <= 1'b0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            err_mem_q[wr_ptr_q]  <= imem_error;
        end
    end

endmodule
